// File: rtl/imm_pkg.sv
// Shared immediate-format codes, widths and FIFO sizing for the encoder and
// the matching immediate extender.
package imm_pkg;

  localparam int XLEN       = 32;
  localparam int FIFO_DEPTH = 2;
  // Pointers wrap by natural overflow, so FIFO_DEPTH must stay a power of two.
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic            range_err;
  } fifo_entry_t;

  // Immediate extender: recovers the immediate carried by an encoded instruction.
  function automatic logic [XLEN-1:0] imm_extend(input logic [XLEN-1:0] i,
                                                 input logic [2:0] src);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (imm_src_e'(src))
      IMM_I: imm = {{20{i[31]}}, i[31:20]};
      IMM_S: imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J: imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U: imm = {i[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Job/result handshake bundle of the immediate encoder.
interface imm_encoder_if
  import imm_pkg::*;
();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ImmSrc;
  logic [XLEN-1:0] ImmVal;
  logic [XLEN-1:0] base;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] instr;
  logic            range_err;

  modport master (
    output in_valid, ImmSrc, ImmVal, base, out_ready,
    input  in_ready, out_valid, instr, range_err
  );

  modport slave (
    input  in_valid, ImmSrc, ImmVal, base, out_ready,
    output in_ready, out_valid, instr, range_err
  );
endinterface

// File: rtl/imm_place.sv
// Combinational immediate bit placement into an instruction word, plus the
// representability check for the selected format.
module imm_place
  import imm_pkg::*;
(
  input  logic [2:0]      imm_src,
  input  logic [XLEN-1:0] imm_val,
  input  logic [XLEN-1:0] base,
  output logic [XLEN-1:0] instr,
  output logic            range_err
);

  logic fits_12;
  logic fits_13;
  logic fits_21;

  // A signed field fits when every bit above its top bit equals that top bit.
  assign fits_12 = (&imm_val[31:11]) || !(|imm_val[31:11]);
  assign fits_13 = (&imm_val[31:12]) || !(|imm_val[31:12]);
  assign fits_21 = (&imm_val[31:20]) || !(|imm_val[31:20]);

  always_comb begin
    instr     = base;
    range_err = 1'b1;
    case (imm_src_e'(imm_src))
      IMM_I: begin
        instr     = {imm_val[11:0], base[19:0]};
        range_err = !fits_12;
      end
      IMM_S: begin
        instr     = {imm_val[11:5], base[24:12], imm_val[4:0], base[6:0]};
        range_err = !fits_12;
      end
      IMM_B: begin
        instr     = {imm_val[12], imm_val[10:5], base[24:12],
                     imm_val[4:1], imm_val[11], base[6:0]};
        range_err = !fits_13 || imm_val[0];
      end
      IMM_J: begin
        instr     = {imm_val[20], imm_val[10:1], imm_val[11],
                     imm_val[19:12], base[11:0]};
        range_err = !fits_21 || imm_val[0];
      end
      IMM_U: begin
        instr     = {imm_val[31:12], base[11:0]};
        range_err = |imm_val[11:0];
      end
      default: begin
        instr     = base;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: accepts encode jobs, places the immediate and buffers the
// result in a 2-entry FIFO. Define IMM_ENCODER_STATS_EN to add err_count.
module imm_encoder
  import imm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  imm_encoder_if.slave bus
`ifdef IMM_ENCODER_STATS_EN
  ,
  output logic [7:0]   err_count
`endif
);

  logic [XLEN-1:0]       placed_instr;
  logic                  placed_err;
  fifo_entry_t           fifo_mem_reg [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_reg;
  logic [FIFO_PTR_W-1:0] rd_ptr_reg;
  logic [FIFO_CNT_W-1:0] count_reg;
  logic                  push;
  logic                  pop;

  imm_place u_place (
    .imm_src   (bus.ImmSrc),
    .imm_val   (bus.ImmVal),
    .base      (bus.base),
    .instr     (placed_instr),
    .range_err (placed_err)
  );

  // Ready depends only on registered occupancy, so out_ready never reaches it.
  assign bus.in_ready  = (count_reg != FIFO_CNT_W'(FIFO_DEPTH));
  assign bus.out_valid = (count_reg != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.instr     = fifo_mem_reg[rd_ptr_reg].instr;
  assign bus.range_err = fifo_mem_reg[rd_ptr_reg].range_err;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          fifo_mem_reg[gi] <= '0;
        end else if (push && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
          fifo_mem_reg[gi] <= '{instr: placed_instr, range_err: placed_err};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef IMM_ENCODER_STATS_EN
  logic [7:0] err_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_reg <= '0;
    end else if (pop && bus.range_err && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random checks of imm_encoder: encodings, range errors,
// backpressure, mid-operation reset, and the optional error counter.
module tb_imm_encoder;
  import imm_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  imm_encoder_if bus ();

`ifdef IMM_ENCODER_STATS_EN
  logic [7:0] err_count;
`endif

  imm_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef IMM_ENCODER_STATS_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one job into an empty FIFO, check the result next cycle, then pop it.
  task automatic do_job(input string tag, input logic [2:0] src, input logic [31:0] val,
                        input logic [31:0] b, input logic [31:0] exp_instr,
                        input logic exp_err);
    bus.ImmSrc   = src;
    bus.ImmVal   = val;
    bus.base     = b;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_instr"}, bus.instr, exp_instr);
    chk({tag, "_range_err"}, 32'(bus.range_err), 32'(exp_err));
    $display("job %s: src=%0d val=%h base=%h -> instr=%h range_err=%0b",
             tag, src, val, b, bus.instr, bus.range_err);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  function automatic logic [31:0] keep_mask(input logic [2:0] src);
    case (src)
      3'd0:        return 32'h000F_FFFF;
      3'd1, 3'd2:  return 32'h01FF_F07F;
      3'd3, 3'd4:  return 32'h0000_0FFF;
      default:     return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic exp_range_err(input logic [2:0] src, input logic [31:0] val);
    longint sv;
    sv = longint'($signed(val));
    case (src)
      3'd0, 3'd1: return !(sv >= -2048 && sv <= 2047);
      3'd2:       return !(sv >= -4096 && sv <= 4095 && val[0] == 1'b0);
      3'd3:       return !(sv >= -1048576 && sv <= 1048575 && val[0] == 1'b0);
      3'd4:       return (val % 32'd4096) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  logic [31:0] got[$];
  logic        c_accepted;
  logic [2:0]  r_src;
  logic [31:0] r_val, r_base, r_raw;
  logic        r_err;

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ImmSrc    = 3'd0;
    bus.ImmVal    = '0;
    bus.base      = '0;

    // Reset state
    repeat (2) tick();
    chk("in_reset_out_valid", 32'(bus.out_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_range_err", 32'(bus.range_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef IMM_ENCODER_STATS_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif

    // Directed encodings
    do_job("i_neg2048", 3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    do_job("i_base_imm", 3'd0, 32'h0000_0005, 32'hFFF0_0093, 32'h0050_0093, 1'b0);
    do_job("s_2047", 3'd1, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0);
    do_job("b_neg4", 3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
    do_job("b_odd", 3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1);
    do_job("j_oor", 3'd3, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1);
    do_job("u_low", 3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
    do_job("u_ok", 3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    do_job("invalid", 3'd5, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
`ifdef IMM_ENCODER_STATS_EN
    chk("err_count_4", 32'(err_count), 32'd4);
`endif

    // Backpressure: three back-to-back jobs with the sink stalled
    bus.ImmSrc    = 3'd0;
    bus.base      = 32'h0000_0013;
    bus.ImmVal    = 32'd1;
    bus.in_valid  = 1'b1;
    tick();
    bus.ImmVal    = 32'd2;
    tick();
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.ImmVal    = 32'd3;
    tick();
    chk("bp_held_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_instr", bus.instr, 32'h0010_0013);
    tick();
    chk("bp_stable_instr", bus.instr, 32'h0010_0013);
    chk("bp_stable_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    c_accepted    = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.out_valid) got.push_back(bus.instr);
      if (bus.in_valid && bus.in_ready) c_accepted = 1'b1;
      tick();
      if (c_accepted) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    chk("bp_c_accepted", 32'(c_accepted), 32'd1);
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp_order_%0d", k), (k < got.size()) ? got[k] : 32'hx,
          32'h0000_0013 | (32'(k + 1) << 20));
      $display("backpressure output %0d: instr=%h", k, (k < got.size()) ? got[k] : 32'hx);
    end

    // Reset with two buffered jobs
    bus.ImmSrc   = 3'd4;
    bus.ImmVal   = 32'h0000_0001;
    bus.base     = 32'h0000_0037;
    bus.in_valid = 1'b1;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_async_valid", 32'(bus.out_valid), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef IMM_ENCODER_STATS_EN
    chk("mid_err_count", 32'(err_count), 32'd0);
`endif
    $display("reset with 2 jobs buffered: out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);

    // 300 error jobs streamed through
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (300) tick();
    bus.in_valid  = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("stream_drained", 32'(bus.out_valid), 32'd0);
`ifdef IMM_ENCODER_STATS_EN
    chk("err_count_sat", 32'(err_count), 32'd255);
    $display("300 error jobs: err_count=%0d", err_count);
`endif

    // Random round-trip, one job per cycle
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      r_raw  = $urandom;
      r_src  = 3'($urandom_range(0, 7));
      r_base = $urandom;
      case ($urandom_range(0, 3))
        0:       r_val = r_raw;
        1:       r_val = $signed(r_raw) >>> $urandom_range(0, 31);
        2:       r_val = ($signed(r_raw) >>> $urandom_range(0, 31)) & ~32'h1;
        default: r_val = r_raw & 32'hFFFF_F000;
      endcase
      r_err        = exp_range_err(r_src, r_val);
      bus.ImmSrc   = r_src;
      bus.ImmVal   = r_val;
      bus.base     = r_base;
      bus.in_valid = 1'b1;
      tick();
      chk("rnd_valid", 32'(bus.out_valid), 32'd1);
      chk("rnd_range_err", 32'(bus.range_err), 32'(r_err));
      chk("rnd_base_bits", bus.instr & keep_mask(r_src), r_base & keep_mask(r_src));
      if (!r_err) chk("rnd_roundtrip", imm_extend(bus.instr, r_src), r_val);
      if (n % 1000 == 999)
        $display("random job %0d: src=%0d val=%h -> instr=%h range_err=%0b",
                 n, r_src, r_val, bus.instr, bus.range_err);
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    chk("rnd_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
